botoes_condicionador: RTL

- Input-side conditioner for the LED puzzle. It turns the eight raw, bouncy push-button lines into clean one-hot, single-cycle toggle pulses.
- It feeds the `botoes` input of the LED matrix controller. That controller expects one pulse per physical press, never a held level.
- It also counts the moves the player has made in the current level, for the control unit and the score display.

---
 rtl/botoes_condicionador.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/botoes_condicionador.sv
// botoes_condicionador: input-side conditioner for the LED puzzle.
// Eight raw, bouncy push buttons become one-hot single-cycle toggle pulses
// (at most one per clock), debounced levels, and a saturating move counter.
// Each button has its own 2-FF synchronizer and debounce FSM. The FSMs feed
// a shared pending register that drains lowest-index-first.

// ---------------------------------------------------------------------------
// Per-button channel: synchronizer + debounce FSM.
// evento_o is a one-cycle strobe, asserted in the cycle the FSM is about to
// enter PRESSIONADO. It is combinational on purpose: the pending bit has to be
// set on the same edge the FSM takes that transition.
// ---------------------------------------------------------------------------
module botoes_condicionador_canal #(
   parameter int DEBOUNCE_CICLOS = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic bruto_i,
   output logic evento_o,
   output logic pressionado_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      SOLTO        = 2'd0,
      VALIDA_PRESS = 2'd1,
      PRESSIONADO  = 2'd2,
      VALIDA_SOLTA = 2'd3
   } estado_t;

   logic            sync1_q;
   logic            s_q;
   estado_t         estado_q;
   logic [CNT_W-1:0] cnt_q;
   logic            pressionado_q;

   // Two-stage synchronizer for the asynchronous raw line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         sync1_q <= bruto_i;
         s_q     <= sync1_q;
      end
   end

   // Debounce FSM: a level change is accepted only after the counter
   // walks 0..DEBOUNCE_CICLOS-1 with the synchronized input stable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q      <= SOLTO;
         cnt_q         <= '0;
         pressionado_q <= 1'b0;
      end else begin
         case (estado_q)
            SOLTO: begin
               if (s_q) begin
                  estado_q <= VALIDA_PRESS;
                  cnt_q    <= '0;
               end
            end
            VALIDA_PRESS: begin
               if (!s_q) begin
                  estado_q <= SOLTO;
               end else if (cnt_q == CNT_MAX) begin
                  estado_q      <= PRESSIONADO;
                  pressionado_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PRESSIONADO: begin
               if (!s_q) begin
                  estado_q <= VALIDA_SOLTA;
                  cnt_q    <= '0;
               end
            end
            VALIDA_SOLTA: begin
               if (s_q) begin
                  estado_q <= PRESSIONADO;
               end else if (cnt_q == CNT_MAX) begin
                  estado_q      <= SOLTO;
                  pressionado_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               estado_q      <= SOLTO;
               pressionado_q <= 1'b0;
            end
         endcase
      end
   end

   // Press strobe: last cycle of a successful press qualification
   assign evento_o      = (estado_q == VALIDA_PRESS) && s_q && (cnt_q == CNT_MAX);
   assign pressionado_o = pressionado_q;

endmodule

// ---------------------------------------------------------------------------
// Top: array of channels, pending queue, one-hot arbiter, move counter.
// ---------------------------------------------------------------------------
module botoes_condicionador #(
   parameter int N_BOTOES        = 8,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int JOGADAS_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_BOTOES-1:0]  botoes_brutos,
   input  logic                 habilita,
   input  logic                 limpa_jogadas,
   output logic [N_BOTOES-1:0]  botoes_pulso,
   output logic [N_BOTOES-1:0]  pressionados,
   output logic                 jogada_valida,
   output logic [JOGADAS_W-1:0] jogadas,
   output logic [N_BOTOES-1:0]  db_pendentes
);

   logic [N_BOTOES-1:0]  evento;
   logic [N_BOTOES-1:0]  pressionado_w;
   logic [N_BOTOES-1:0]  sel;
   logic                 emite;

   logic [N_BOTOES-1:0]  pendente_q, pendente_d;
   logic [N_BOTOES-1:0]  pulso_q, pulso_d;
   logic                 valida_q, valida_d;
   logic [JOGADAS_W-1:0] jogadas_q, jogadas_d;

   for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
      botoes_condicionador_canal #(
         .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
      ) u_canal (
         .clk          (clk),
         .rst          (rst),
         .bruto_i      (botoes_brutos[i]),
         .evento_o     (evento[i]),
         .pressionado_o(pressionado_w[i])
      );
   end

   // Lowest set pending bit (two's-complement isolate trick)
   assign sel   = pendente_q & (~pendente_q + N_BOTOES'(1));
   assign emite = habilita && (pendente_q != '0);

   // Queue / arbiter / counter next state. Clear beats everything; with
   // habilita low the queue is flushed and new events are dropped. The
   // emitted bit is cleared before OR-ing in new events so a same-index
   // re-press is kept and emitted later.
   always_comb begin
      pendente_d = '0;
      pulso_d    = '0;
      valida_d   = 1'b0;
      jogadas_d  = jogadas_q;
      if (limpa_jogadas) begin
         jogadas_d = '0;
      end else if (habilita) begin
         pendente_d = (pendente_q & ~sel) | evento;
         if (emite) begin
            pulso_d  = sel;
            valida_d = 1'b1;
            if (jogadas_q != '1)
               jogadas_d = jogadas_q + JOGADAS_W'(1);
         end
      end
   end

   // Register queue, pulse outputs and move counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pendente_q <= '0;
         pulso_q    <= '0;
         valida_q   <= 1'b0;
         jogadas_q  <= '0;
      end else begin
         pendente_q <= pendente_d;
         pulso_q    <= pulso_d;
         valida_q   <= valida_d;
         jogadas_q  <= jogadas_d;
      end
   end

   assign botoes_pulso  = pulso_q;
   assign jogada_valida = valida_q;
   assign jogadas       = jogadas_q;
   assign pressionados  = pressionado_w;
   assign db_pendentes  = pendente_q;

endmodule
